// File: rtl/alu_seq.sv
// alu_seq: registered ALU with Z/N/C/V flags and a valid/ready handshake.
// Define ALU_SEQ_MUL_EN to add an iterative shift-add multiplier (opcode 1011).
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic [3:0]       flags
);
  logic [WIDTH:0] add_r, sub_r;
  logic [WIDTH-1:0] nr;
  logic nc, nv, unused;
  logic [3:0] nf;
  assign add_r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (alu_op == 4'b1001) & flags[1]};
  assign sub_r = {1'b0, a} - {1'b0, b};
  always_comb begin
    nr = '0;
    nc = 1'b0;
    nv = 1'b0;
    unused = 1'b0;
    case (alu_op)
      4'b0000, 4'b1001: begin
        nr = add_r[WIDTH-1:0];
        nc = add_r[WIDTH];
        nv = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0001, 4'b1010: begin
        nr = sub_r[WIDTH-1:0];
        nc = sub_r[WIDTH];
        nv = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0010: nr = b;
      4'b0011: nr = a & b;
      4'b0100: nr = a | b;
      4'b0101: nr = a ^ b;
      4'b0110: nr = ~a;
      4'b0111: begin
        nr = {a[WIDTH-2:0], 1'b0};
        nc = a[WIDTH-1];
      end
      4'b1000: begin
        nr = {1'b0, a[WIDTH-1:1]};
        nc = a[0];
      end
      default: unused = 1'b1;
    endcase
  end
  assign nf = unused ? 4'b1000 : {nr == '0, nr[WIDTH-1], nc, nv};
`ifdef ALU_SEQ_MUL_EN
  localparam int CNT_W = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, MUL} state_t;
  state_t state;
  logic [2*WIDTH-1:0] acc, mcand, acc_nx;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  assign acc_nx = acc + (mplier[0] ? mcand : '0);
  assign in_ready = state == IDLE;
`else
  assign in_ready = 1'b1;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      result <= '0;
      flags <= 4'b0000;
      out_valid <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      state <= IDLE;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      if (state == MUL) begin
        acc <= acc_nx;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state <= IDLE;
          result <= acc_nx[WIDTH-1:0];
          flags <= {acc_nx[WIDTH-1:0] == '0, acc_nx[WIDTH-1], |acc_nx[2*WIDTH-1:WIDTH], 1'b0};
          out_valid <= 1'b1;
        end
      end else
`endif
      if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
        if (alu_op == 4'b1011) begin
          state <= MUL;
          acc <= '0;
          mcand <= {{WIDTH{1'b0}}, a};
          mplier <= b;
          cnt <= '0;
        end else
`endif
        begin
          if (alu_op != 4'b1010) result <= nr;
          flags <= nf;
          out_valid <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed plus random scoreboard bench for alu_seq (WIDTH=8).
module tb_alu_seq;
  typedef struct {
    logic [7:0] r;
    logic [3:0] f;
    string tag;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, out_valid;
  logic [7:0] a = '0, b = '0, result;
  logic [3:0] alu_op = '0, flags;
  logic [7:0] mres = '0;
  logic [3:0] mflags = '0;
  exp_t sb[$];
  int checks = 0, errors = 0;
  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .alu_op(alu_op), .result(result), .out_valid(out_valid), .flags(flags)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (!rst && out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL unexpected out_valid result %h flags %b", result, flags);
      end else begin
        exp_t e;
        e = sb.pop_front();
        assert (result === e.r) else begin
          errors++;
          $error("FAIL %s result got %h exp %h", e.tag, result, e.r);
        end
        checks++;
        assert (flags === e.f) else begin
          errors++;
          $error("FAIL %s flags got %b exp %b", e.tag, flags, e.f);
        end
      end
    end
  function automatic void model(input logic [7:0] x, y, input logic [3:0] op,
                                output logic [7:0] r, output logic [3:0] f);
    int s, ss;
    logic [7:0] d;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    r = mres;
    d = 8'h00;
    if (op == 4'd0 || op == 4'd9) begin
      s = int'(x) + int'(y) + ((op == 4'd9) ? int'(mflags[1]) : 0);
      ss = int'($signed(x)) + int'($signed(y)) + ((op == 4'd9) ? int'(mflags[1]) : 0);
      d = s[7:0];
      c = s > 255;
      v = ss > 127 || ss < -128;
    end else if (op == 4'd1 || op == 4'd10) begin
      s = int'(x) - int'(y);
      ss = int'($signed(x)) - int'($signed(y));
      d = s[7:0];
      c = x < y;
      v = ss > 127 || ss < -128;
    end else if (op == 4'd2) d = y;
    else if (op == 4'd3) d = x & y;
    else if (op == 4'd4) d = x | y;
    else if (op == 4'd5) d = x ^ y;
    else if (op == 4'd6) d = ~x;
    else if (op == 4'd7) begin
      d = {x[6:0], 1'b0};
      c = x[7];
    end else if (op == 4'd8) begin
      d = {1'b0, x[7:1]};
      c = x[0];
    end else begin
      r = 8'h00;
      f = 4'b1000;
      return;
    end
    if (op != 4'd10) r = d;
    f = {d == 8'h00, d[7], c, v};
  endfunction
  task automatic send(input logic [7:0] x, y, input logic [3:0] op,
                      input logic [7:0] er, input logic [3:0] ef, input string tag);
    @(negedge clk);
    a = x;
    b = y;
    alu_op = op;
    in_valid = 1'b1;
    checks++;
    assert (in_ready === 1'b1) else begin
      errors++;
      $error("FAIL %s in_ready got %b exp 1", tag, in_ready);
    end
    sb.push_back('{er, ef, tag});
    mres = er;
    mflags = ef;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk) in_valid = 1'b0;
  endtask
  initial begin
    logic [7:0] x, y, er;
    logic [3:0] op, ef;
    int lat;
    #12;
    checks += 3;
    assert (result === 8'h00) else begin errors++; $error("FAIL reset result got %h exp 00", result); end
    assert (flags === 4'b0000) else begin errors++; $error("FAIL reset flags got %b exp 0000", flags); end
    assert (out_valid === 1'b0) else begin errors++; $error("FAIL reset out_valid got %b exp 0", out_valid); end
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checks++;
    assert (in_ready === 1'b1) else begin errors++; $error("FAIL reset in_ready got %b exp 1", in_ready); end
    send(8'hF0, 8'h20, 4'd0, 8'h10, 4'b0010, "add_f0_20");
    idle(1);
    send(8'h03, 8'h05, 4'd1, 8'hFE, 4'b0110, "sub_03_05");
    send(8'h05, 8'h05, 4'd10, 8'hFE, 4'b1000, "cmp_05_05");
    send(8'h7F, 8'h01, 4'd0, 8'h80, 4'b0101, "add_7f_01");
    send(8'h00, 8'h00, 4'd9, 8'h00, 4'b1000, "adc_c0");
    send(8'hFF, 8'h01, 4'd0, 8'h00, 4'b1010, "add_ff_01");
    send(8'h00, 8'h00, 4'd9, 8'h01, 4'b0000, "adc_c1");
    send(8'h11, 8'h5A, 4'd2, 8'h5A, 4'b0000, "mov");
    send(8'hF0, 8'h3C, 4'd3, 8'h30, 4'b0000, "and");
    send(8'h0F, 8'h80, 4'd4, 8'h8F, 4'b0100, "or");
    send(8'hFF, 8'h0F, 4'd5, 8'hF0, 4'b0100, "xor");
    send(8'h00, 8'h33, 4'd6, 8'hFF, 4'b0100, "not");
    send(8'h81, 8'h00, 4'd7, 8'h02, 4'b0010, "shl");
    send(8'h01, 8'h00, 4'd8, 8'h00, 4'b1010, "shr");
    send(8'h80, 8'h01, 4'd1, 8'h7F, 4'b0001, "sub_ovf");
    send(8'h12, 8'h34, 4'd15, 8'h00, 4'b1000, "unused_op");
`ifndef ALU_SEQ_MUL_EN
    send(8'h0C, 8'h0B, 4'd11, 8'h00, 4'b1000, "mul_disabled");
`endif
    idle(2);
    for (int i = 0; i < 16; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      do op = 4'($urandom_range(0, 15)); while (op == 4'd11);
      model(x, y, op, er, ef);
      send(x, y, op, er, ef, "rand");
    end
    idle(2);
`ifdef ALU_SEQ_MUL_EN
    send(8'h0C, 8'h0B, 4'd11, 8'h84, 4'b0100, "mul_0c_0b");
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) in_valid = 1'b0;
      if (k == 2) begin
        a = 8'h01;
        b = 8'h01;
        alu_op = 4'd0;
        in_valid = 1'b1;
      end
      if (k == 8) in_valid = 1'b0;
      checks++;
      if (out_valid) begin
        lat = k - 1;
        assert (in_ready === 1'b1) else begin errors++; $error("FAIL mul_done in_ready got %b exp 1", in_ready); end
      end else begin
        assert (in_ready === 1'b0) else begin errors++; $error("FAIL mul_busy in_ready got %b exp 0", in_ready); end
      end
    end
    checks++;
    assert (lat === 8) else begin errors++; $error("FAIL mul_latency got %0d exp 8", lat); end
    idle(3);
    send(8'h10, 8'h10, 4'd11, 8'h00, 4'b1010, "mul_10_10");
    idle(12);
    send(8'h0C, 8'h0B, 4'd11, 8'h84, 4'b0100, "mul_reset");
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    sb.delete();
    checks += 3;
    assert (result === 8'h00) else begin errors++; $error("FAIL midmul result got %h exp 00", result); end
    assert (flags === 4'b0000) else begin errors++; $error("FAIL midmul flags got %b exp 0000", flags); end
    assert (out_valid === 1'b0) else begin errors++; $error("FAIL midmul out_valid got %b exp 0", out_valid); end
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checks++;
    assert (in_ready === 1'b1) else begin errors++; $error("FAIL midmul in_ready got %b exp 1", in_ready); end
    mres = 8'h00;
    mflags = 4'b0000;
    idle(12);
`endif
    idle(3);
    checks++;
    assert (sb.size() === 0) else begin errors++; $error("FAIL missing out_valid pending %0d exp 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
